// File: rtl/rf_fwd_scoreboard_if.sv
// Signal bundle between the ID stage and the operand forwarding / load-use hazard unit.
// The master modport is the ID side. The slave modport is the scoreboard itself.
interface rf_fwd_scoreboard_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned NRD    = 2,
    parameter int unsigned CNT_W  = 16
);
    logic                    freeze;
    logic                    flush;
    logic                    issue_valid;
    logic                    issue_we;
    logic [ADDR_W-1:0]       issue_waddr;
    logic                    issue_is_load;
    logic [DEPTH*DATA_W-1:0] stage_wdata;
    logic [NRD-1:0]          rd_en;
    logic [NRD*ADDR_W-1:0]   rd_addr;
    logic [NRD*DATA_W-1:0]   rf_rdata;
    logic [NRD*DATA_W-1:0]   rd_data;
    logic [NRD-1:0]          rd_fwd;
    logic                    stall_req;
    logic [CNT_W-1:0]        perf_stall_cnt;

    modport master (
        output freeze, flush, issue_valid, issue_we, issue_waddr, issue_is_load,
        output stage_wdata, rd_en, rd_addr, rf_rdata,
        input  rd_data, rd_fwd, stall_req, perf_stall_cnt
    );

    modport slave (
        input  freeze, flush, issue_valid, issue_we, issue_waddr, issue_is_load,
        input  stage_wdata, rd_en, rd_addr, rf_rdata,
        output rd_data, rd_fwd, stall_req, perf_stall_cnt
    );
endinterface

// File: rtl/rf_fwd_scoreboard.sv
// ID-stage operand forwarding and load-use hazard unit.
// It tracks one tag slot per downstream stage, from slot 0 (EX) to slot DEPTH-1 (WB).
module rf_fwd_scoreboard #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned NRD        = 2,
    parameter int unsigned LOAD_STAGE = 1,
    parameter int unsigned CNT_W      = 16
) (
    input logic                clk,
    input logic                rst,
    rf_fwd_scoreboard_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic              is_load;
    } slot_t;

    if (DEPTH < 1) begin : g_bad_depth
        $error("rf_fwd_scoreboard: DEPTH must be at least 1");
    end
    if (NRD < 1) begin : g_bad_nrd
        $error("rf_fwd_scoreboard: NRD must be at least 1");
    end
    if (LOAD_STAGE >= DEPTH) begin : g_bad_load_stage
        $error("rf_fwd_scoreboard: LOAD_STAGE must be below DEPTH");
    end

    slot_t                 slots [DEPTH];
    slot_t                 issue_tag;
    logic [DEPTH-1:0]      early;
    logic [NRD*DATA_W-1:0] rd_data_c;
    logic [NRD-1:0]        rd_fwd_c;
    logic                  stall_c;
    logic                  hit;
    logic                  ready;
    logic [DATA_W-1:0]     fwd_data;
    logic [CNT_W-1:0]      stall_cnt;

    // A load's data does not exist yet in the slots ahead of LOAD_STAGE.
    for (genvar g = 0; g < DEPTH; g++) begin : g_early
        assign early[g] = (g < LOAD_STAGE);
    end

    // Per-port match. The scan runs from the oldest slot to the youngest, so the youngest match wins.
    always_comb begin
        rd_data_c = bus.rf_rdata;
        rd_fwd_c  = '0;
        stall_c   = 1'b0;
        hit       = 1'b0;
        ready     = 1'b0;
        fwd_data  = '0;
        for (int p = 0; p < int'(NRD); p++) begin
            hit      = 1'b0;
            ready    = 1'b0;
            fwd_data = '0;
            for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
                if (bus.rd_en[p] && slots[k].valid && slots[k].we &&
                    (slots[k].waddr == bus.rd_addr[p*ADDR_W +: ADDR_W]) &&
                    (bus.rd_addr[p*ADDR_W +: ADDR_W] != '0)) begin
                    hit      = 1'b1;
                    ready    = !(slots[k].is_load && early[k]);
                    fwd_data = bus.stage_wdata[k*DATA_W +: DATA_W];
                end
            end
            if (hit && ready) begin
                rd_data_c[p*DATA_W +: DATA_W] = fwd_data;
                rd_fwd_c[p]                   = 1'b1;
            end
            stall_c = stall_c | (hit && !ready);
        end
    end

    // Slot 0 takes a bubble while the issuing instruction is held by a hazard.
    always_comb begin
        issue_tag.valid   = bus.issue_valid && !stall_c;
        issue_tag.we      = bus.issue_we;
        issue_tag.waddr   = bus.issue_waddr;
        issue_tag.is_load = bus.issue_is_load;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                slots[k] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            if (stall_c && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (bus.flush) begin
                for (int k = 0; k < int'(DEPTH); k++) begin
                    slots[k] <= '0;
                end
            end else if (!bus.freeze) begin
                for (int k = int'(DEPTH) - 1; k > 0; k--) begin
                    slots[k] <= slots[k-1];
                end
                slots[0] <= issue_tag;
            end
        end
    end

    assign bus.rd_data        = rd_data_c;
    assign bus.rd_fwd         = rd_fwd_c;
    assign bus.stall_req      = stall_c;
    assign bus.perf_stall_cnt = stall_cnt;
endmodule

// File: tb/tb_rf_fwd_scoreboard.sv
// Bench for rf_fwd_scoreboard: directed scenarios plus random traffic.
// Outputs are checked against a queue-based model of the in-flight writes.
module tb_rf_fwd_scoreboard;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned DEPTH      = 3;
    localparam int unsigned NRD        = 2;
    localparam int unsigned LOAD_STAGE = 1;
    localparam int unsigned CNT_W      = 16;
    localparam int          SAT        = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    rf_fwd_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NRD(NRD), .CNT_W(CNT_W)) bus ();

    rf_fwd_scoreboard #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NRD(NRD),
        .LOAD_STAGE(LOAD_STAGE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: a list of in-flight writes, youngest first. Each write carries its age in stages.
    typedef struct {
        bit v;
        bit we;
        int addr;
        bit ld;
    } ent_t;

    ent_t                  mq[$];
    int                    m_cnt;
    logic [NRD*DATA_W-1:0] exp_data;
    logic [NRD-1:0]        exp_fwd;
    logic [NRD-1:0]        exp_pstall;
    logic                  exp_stall;

    function automatic void model_reset();
        ent_t e;
        e = '{v: 1'b0, we: 1'b0, addr: 0, ld: 1'b0};
        mq.delete();
        for (int k = 0; k < int'(DEPTH); k++) mq.push_back(e);
        m_cnt = 0;
    endfunction

    function automatic void model_eval();
        exp_data   = bus.rf_rdata;
        exp_fwd    = '0;
        exp_pstall = '0;
        exp_stall  = 1'b0;
        for (int p = 0; p < int'(NRD); p++) begin
            int a;
            a = int'(bus.rd_addr[p*ADDR_W +: ADDR_W]);
            if (!bus.rd_en[p] || a == 0) continue;
            for (int k = 0; k < int'(DEPTH); k++) begin
                if (mq[k].v && mq[k].we && mq[k].addr == a) begin
                    if (mq[k].ld && k < int'(LOAD_STAGE)) begin
                        exp_pstall[p] = 1'b1;
                        exp_stall     = 1'b1;
                    end else begin
                        exp_fwd[p] = 1'b1;
                        exp_data[p*DATA_W +: DATA_W] = bus.stage_wdata[k*DATA_W +: DATA_W];
                    end
                    break;
                end
            end
        end
    endfunction

    function automatic void model_edge();
        ent_t e;
        model_eval();
        if (exp_stall && m_cnt < SAT) m_cnt++;
        if (bus.flush) begin
            foreach (mq[k]) mq[k].v = 1'b0;
        end else if (!bus.freeze) begin
            e.v    = bus.issue_valid && !exp_stall;
            e.we   = bus.issue_we;
            e.addr = int'(bus.issue_waddr);
            e.ld   = bus.issue_is_load;
            mq.push_front(e);
            void'(mq.pop_back());
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_idle();
        bus.freeze        = 1'b0;
        bus.flush         = 1'b0;
        bus.issue_valid   = 1'b0;
        bus.issue_we      = 1'b0;
        bus.issue_waddr   = '0;
        bus.issue_is_load = 1'b0;
        bus.rd_en         = '0;
        bus.rd_addr       = '0;
        bus.rf_rdata      = {$urandom, $urandom};
        bus.stage_wdata   = {$urandom, $urandom, $urandom};
    endtask

    task automatic drive_issue(input bit we, input int addr, input bit ld);
        bus.issue_valid   = 1'b1;
        bus.issue_we      = we;
        bus.issue_waddr   = ADDR_W'(addr);
        bus.issue_is_load = ld;
    endtask

    task automatic drive_rd(input int p, input int addr);
        bus.rd_en[p] = 1'b1;
        bus.rd_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    endtask

    task automatic drain();
        drive_idle();
        repeat (DEPTH + 1) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        drive_rd(0, 7);
        drive_rd(1, 13);
        #3;
        checks++; if (bus.rd_fwd !== 2'b00) begin errors++; $display("FAIL reset_fwd: got %b want 00", bus.rd_fwd); end
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall_req); end
        checks++; if (bus.perf_stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", bus.perf_stall_cnt); end
        checks++; if (bus.rd_data !== bus.rf_rdata) begin errors++; $display("FAIL reset_data: got %h want %h", bus.rd_data, bus.rf_rdata); end
        #4 rst = 1'b1;
        model_reset();
        drive_idle();
        tick();
    endtask

    task automatic test_alu_fwd();
        drain();
        drive_issue(1'b1, 8, 1'b0);
        #1; tick();
        drive_idle();
        bus.stage_wdata[DATA_W-1:0] = 32'h1234;
        drive_rd(0, 8);
        #1;
        checks++; if (bus.rd_data[DATA_W-1:0] !== 32'h1234) begin errors++; $display("FAIL alu_data: got %h want 1234", bus.rd_data[DATA_W-1:0]); end
        checks++; if (bus.rd_fwd[0] !== 1'b1) begin errors++; $display("FAIL alu_fwd: got %b want 1", bus.rd_fwd[0]); end
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b want 0", bus.stall_req); end
        tick();
    endtask

    task automatic test_load_use();
        int base;
        drain();
        base = m_cnt;
        drive_issue(1'b1, 9, 1'b1);
        #1; tick();
        drive_idle();
        drive_rd(1, 9);
        drive_issue(1'b1, 3, 1'b0);
        #1;
        checks++; if (bus.stall_req !== 1'b1) begin errors++; $display("FAIL ldu_stall: got %b want 1", bus.stall_req); end
        tick();
        bus.stage_wdata[DATA_W +: DATA_W] = 32'hCAFE;
        drive_rd(0, 3);
        #1;
        checks++; if (bus.perf_stall_cnt !== 16'(base + 1)) begin errors++; $display("FAIL ldu_cnt: got %0d want %0d", bus.perf_stall_cnt, base + 1); end
        checks++; if (bus.rd_data[DATA_W +: DATA_W] !== 32'hCAFE) begin errors++; $display("FAIL ldu_data: got %h want cafe", bus.rd_data[DATA_W +: DATA_W]); end
        checks++; if (bus.rd_fwd !== 2'b10) begin errors++; $display("FAIL ldu_fwd: got %b want 10", bus.rd_fwd); end
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL ldu_release: got %b want 0", bus.stall_req); end
        tick();
        drive_idle();
    endtask

    task automatic test_youngest();
        drain();
        drive_issue(1'b1, 0, 1'b0); #1; tick();
        drive_issue(1'b1, 5, 1'b0); #1; tick();
        drive_issue(1'b1, 5, 1'b0); #1; tick();
        drive_idle();
        bus.stage_wdata = {32'hC, 32'hB, 32'hA};
        drive_rd(0, 5);
        drive_rd(1, 0);
        #1;
        checks++; if (bus.rd_data[DATA_W-1:0] !== 32'hA) begin errors++; $display("FAIL young_data: got %h want a", bus.rd_data[DATA_W-1:0]); end
        checks++; if (bus.rd_fwd !== 2'b01) begin errors++; $display("FAIL young_fwd: got %b want 01", bus.rd_fwd); end
        checks++; if (bus.rd_data[DATA_W +: DATA_W] !== bus.rf_rdata[DATA_W +: DATA_W]) begin
            errors++; $display("FAIL r0_data: got %h want %h", bus.rd_data[DATA_W +: DATA_W], bus.rf_rdata[DATA_W +: DATA_W]);
        end
        tick();
    endtask

    task automatic test_freeze_flush();
        int base;
        drain();
        base = m_cnt;
        drive_issue(1'b1, 12, 1'b1);
        #1; tick();
        drive_idle();
        drive_rd(0, 12);
        bus.freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.stall_req !== 1'b1) begin errors++; $display("FAIL frz_stall%0d: got %b want 1", i, bus.stall_req); end
            tick();
        end
        #1;
        checks++; if (bus.perf_stall_cnt !== 16'(base + 3)) begin errors++; $display("FAIL frz_cnt: got %0d want %0d", bus.perf_stall_cnt, base + 3); end
        bus.flush = 1'b1;
        tick();
        bus.flush  = 1'b0;
        bus.freeze = 1'b0;
        #1;
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", bus.stall_req); end
        checks++; if (bus.rd_fwd[0] !== 1'b0) begin errors++; $display("FAIL flush_fwd: got %b want 0", bus.rd_fwd[0]); end
        checks++; if (bus.perf_stall_cnt !== 16'(base + 4)) begin errors++; $display("FAIL flush_cnt: got %0d want %0d", bus.perf_stall_cnt, base + 4); end
        tick();
    endtask

    task automatic test_retire();
        drain();
        drive_issue(1'b1, 17, 1'b0);
        #1; tick();
        for (int k = 0; k < int'(DEPTH); k++) begin
            drive_idle();
            drive_rd(1, 17);
            #1;
            checks++; if (bus.rd_fwd[1] !== 1'b1) begin errors++; $display("FAIL retire_fwd%0d: got %b want 1", k, bus.rd_fwd[1]); end
            checks++; if (bus.rd_data[DATA_W +: DATA_W] !== bus.stage_wdata[k*DATA_W +: DATA_W]) begin
                errors++; $display("FAIL retire_data%0d: got %h want %h", k, bus.rd_data[DATA_W +: DATA_W], bus.stage_wdata[k*DATA_W +: DATA_W]);
            end
            tick();
        end
        drive_idle();
        drive_rd(1, 17);
        #1;
        checks++; if (bus.rd_fwd[1] !== 1'b0) begin errors++; $display("FAIL retired_fwd: got %b want 0", bus.rd_fwd[1]); end
        checks++; if (bus.rd_data[DATA_W +: DATA_W] !== bus.rf_rdata[DATA_W +: DATA_W]) begin
            errors++; $display("FAIL retired_data: got %h want %h", bus.rd_data[DATA_W +: DATA_W], bus.rf_rdata[DATA_W +: DATA_W]);
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            drive_idle();
            bus.freeze        = ($urandom % 8) == 0;
            bus.flush         = ($urandom % 32) == 0;
            bus.issue_valid   = $urandom % 2;
            bus.issue_we      = ($urandom % 4) != 0;
            bus.issue_waddr   = ADDR_W'($urandom % 4);
            bus.issue_is_load = ($urandom % 3) == 0;
            bus.rd_en         = NRD'($urandom);
            for (int p = 0; p < int'(NRD); p++) bus.rd_addr[p*ADDR_W +: ADDR_W] = ADDR_W'($urandom % 4);
            #1;
            model_eval();
            checks++; if (bus.stall_req !== exp_stall) begin errors++; $display("FAIL rnd_stall@%0d: got %b want %b", n, bus.stall_req, exp_stall); end
            checks++; if (bus.rd_fwd !== exp_fwd) begin errors++; $display("FAIL rnd_fwd@%0d: got %b want %b", n, bus.rd_fwd, exp_fwd); end
            checks++; if (bus.perf_stall_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", n, bus.perf_stall_cnt, m_cnt); end
            for (int p = 0; p < int'(NRD); p++) begin
                if (!exp_pstall[p]) begin
                    checks++;
                    if (bus.rd_data[p*DATA_W +: DATA_W] !== exp_data[p*DATA_W +: DATA_W]) begin
                        errors++; $display("FAIL rnd_data%0d@%0d: got %h want %h", p, n, bus.rd_data[p*DATA_W +: DATA_W], exp_data[p*DATA_W +: DATA_W]);
                    end
                end
            end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_reset_midstall();
        drain();
        drive_issue(1'b1, 9, 1'b1);
        #1; tick();
        drive_idle();
        drive_rd(0, 9);
        bus.freeze = 1'b1;
        #1;
        checks++; if (bus.stall_req !== 1'b1) begin errors++; $display("FAIL mid_pre_stall: got %b want 1", bus.stall_req); end
        tick();
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL mid_stall: got %b want 0", bus.stall_req); end
        checks++; if (bus.perf_stall_cnt !== 16'h0) begin errors++; $display("FAIL mid_cnt: got %h want 0", bus.perf_stall_cnt); end
        checks++; if (bus.rd_fwd[0] !== 1'b0) begin errors++; $display("FAIL mid_fwd: got %b want 0", bus.rd_fwd[0]); end
        checks++; if (bus.rd_data[DATA_W-1:0] !== bus.rf_rdata[DATA_W-1:0]) begin
            errors++; $display("FAIL mid_data: got %h want %h", bus.rd_data[DATA_W-1:0], bus.rf_rdata[DATA_W-1:0]);
        end
        drive_idle();
        model_reset();
        #1 rst = 1'b1;
        tick();
        drive_rd(0, 9);
        #1;
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL post_rst_stall: got %b want 0", bus.stall_req); end
        tick();
    endtask

    task automatic test_saturation();
        drain();
        drive_issue(1'b1, 9, 1'b1);
        #1; tick();
        drive_idle();
        drive_rd(0, 9);
        bus.freeze = 1'b1;
        repeat (SAT - 1) tick();
        checks++; if (bus.perf_stall_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL sat_pre: got %0d want %0d", bus.perf_stall_cnt, m_cnt); end
        checks++; if (bus.perf_stall_cnt === 16'hFFFF) begin errors++; $display("FAIL sat_early: got %h want below ffff", bus.perf_stall_cnt); end
        repeat (4) tick();
        checks++; if (bus.perf_stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", bus.perf_stall_cnt); end
        checks++; if (bus.stall_req !== 1'b1) begin errors++; $display("FAIL sat_stall: got %b want 1", bus.stall_req); end
        drive_idle();
        bus.flush = 1'b1;
        tick();
        drive_idle();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_youngest();
        test_freeze_flush();
        test_retire();
        test_random();
        test_reset_midstall();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_fwd_scoreboard.md
Name: rf_fwd_scoreboard

Overview:
Parametrised operand-forwarding and load-use hazard unit for the ID stage of the pipelined core. It replaces the fixed three forwarding buses (EX/MEM/WB to ID) and the separate load-use stall request with a single block. The block holds a shifting tag queue of in-flight register writes, one slot per downstream stage. It also serves NRD read ports with forwarded data and raises a stall request when a needed value is not yet produced.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width
DEPTH, 3, number of tracked downstream stages (slot 0 = EX, slot DEPTH-1 = WB)
NRD, 2, number of ID read ports
LOAD_STAGE, 1, first slot index at which a load's data is valid (MEM); range 0..DEPTH-1
CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
freeze  in  1  whole downstream pipeline held this cycle (from CTRL)
flush  in  1  kill all in-flight entries
issue_valid  in  1  ID presents an instruction this cycle
issue_we  in  1  issued instruction writes a register
issue_waddr  in  ADDR_W  destination register
issue_is_load  in  1  issued instruction is a load
stage_wdata  in  DEPTH*DATA_W  live result of each slot's stage; slot k at bits [k*DATA_W +: DATA_W]
rd_en  in  NRD  read port p active
rd_addr  in  NRD*ADDR_W  read addresses
rf_rdata  in  NRD*DATA_W  register-file read data
rd_data  out  NRD*DATA_W  resolved operand per port
rd_fwd  out  NRD  port p was served from a slot
stall_req  out  1  load-use hazard; ID must hold
perf_stall_cnt  out  CNT_W  saturating count of stall_req cycles

Behaviour:
- Slot state: valid, we, waddr, is_load per slot; DEPTH slots total.
- Reset (rst=0, async): all slot valid=0 and perf_stall_cnt=0. The combinational outputs then give rd_fwd=0, rd_data=rf_rdata and stall_req=0.
- Slot update, evaluated on the clk rising edge, in priority order:
  - flush=1: all slots become invalid next cycle. Flush has priority over freeze.
  - else freeze=1: all slots hold.
  - else: slot k moves to slot k+1 for k<DEPTH-1, and slot DEPTH-1 is retired.
  - Slot 0 loads the issue tag when issue_valid & ~stall_req. Otherwise slot 0 loads a bubble (valid=0).
- Match for port p, slot k: rd_en[p] & slot valid & slot we & waddr==rd_addr[p] & rd_addr[p]!=0.
- Priority: the lowest matching slot index (youngest) wins. Older matches are ignored.
- Readiness: the winning slot k is ready unless is_load & k<LOAD_STAGE.
- If the winner is ready: rd_data[p] = stage_wdata slot k and rd_fwd[p]=1.
- If there is no match: rd_data[p]=rf_rdata[p] and rd_fwd[p]=0. Address 0 always takes this path.
- stall_req = OR over ports of (winner exists & not ready). This is purely combinational with zero latency. rd_data on a stalled port is don't-care.
- Register-file write-through at WB is not this block's job. Slot DEPTH-1 forwards, so a same-cycle RF write/read is covered.
- perf_stall_cnt increments by 1 on each clock edge with stall_req=1, and saturates at all-ones. It is not cleared by flush or freeze.
- freeze together with a hazard: stall_req stays asserted and the slots hold, so no tag is lost.
- Expected latency: an ALU dependency costs 0 stall cycles. With the default configuration, a load followed by a dependent instruction costs exactly 1 stall cycle.
- Elaboration must reject LOAD_STAGE>=DEPTH, and must reject DEPTH<1 or NRD<1.

Test Plan:
- ALU forward: issue we=1 waddr=8, next cycle rd_addr[0]=8 with stage_wdata slot0=0x1234 -> rd_data[0]=0x1234, rd_fwd[0]=1, stall_req=0.
- Load-use: issue load waddr=9, next cycle port1 reads 9 -> stall_req=1 for 1 cycle and perf_stall_cnt=1. The following cycle the load sits in slot1, and with slot1 data 0xCAFE -> rd_data[1]=0xCAFE, stall_req=0, and slot0 is a bubble.
- Youngest wins: slot0 and slot1 both write r5 (data 0xA / 0xB) -> rd_data=0xA. Reading r0 while a slot targets r0 -> rd_fwd=0 and rd_data=rf_rdata.
- Freeze/flush: freeze=1 for 3 cycles with a load pending in slot0 -> slots unchanged, stall_req held, counter +3. Then flush=1 together with freeze=1 -> next cycle all slots invalid and stall_req=0.
- Retire: a write issued with no further issues -> forwarded from slot0..2 for 3 cycles, and on the 4th cycle rd_fwd=0.
- Reset mid-stall (rst low asynchronously between edges) -> slots cleared immediately, stall_req=0, perf_stall_cnt=0. Separately, force 2^CNT_W stall cycles -> counter holds at 0xFFFF.
